// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
// Exports: arb_state_t, mem_type_t size/sign codes, MEM_SIZE_WORD.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    // Load/store type: bit 2 = unsigned, bits 1:0 = log2(bytes).
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_type_t;

    localparam logic [2:0] MEM_SIZE_WORD = MEM_W;

    localparam int WD_CNT_W = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data, memory and error signals around the arbiter.
// master: arbiter view; slave: pipeline + memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_size;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_size;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              err_timeout;

    modport master (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata, d_size,
        input  mem_ack, mem_rdata,
        output if_rdata, if_valid, if_stall,
        output d_rdata, d_valid, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        output err_timeout
    );

    modport slave (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata, d_size,
        output mem_ack, mem_rdata,
        input  if_rdata, if_valid, if_stall,
        input  d_rdata, d_valid, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        input  err_timeout
    );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Saturating 8-bit wait counter that flags a memory that never acks.
// Ports: CLK, RST, clear, enable (waiting cycle), expire (last allowed cycle).
module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WD_CNT_W-1:0] CNT_MAX = '1;
    // Expire on the cycle the count would reach TIMEOUT, so mem_req is
    // held for exactly TIMEOUT unacknowledged cycles.
    localparam logic [WD_CNT_W-1:0] LAST =
        (TIMEOUT == 0) ? '0 : WD_CNT_W'(TIMEOUT - 1);
    localparam logic ENABLED = (TIMEOUT != 0);

    logic [WD_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = ENABLED & enable & ~clear & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and MEM; data side has priority.
// Ports: CLK, RST, bus (master modport: fetch/data/memory/error signals).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RST,
    mem_port_arbiter_if.master  bus
);

    arb_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_size_q, mem_size_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_valid_q, d_valid_d;
    logic              discard_q, discard_d;
    logic              err_q, err_d;

    logic              busy;
    logic              wd_expire;
    logic              done;
    logic              drop;
    logic              d_pend;
    logic              f_pend;
    logic              issue_d;
    logic              issue_f;
    logic [DATA_W-1:0] rsp;

    // A request is still pending only until its valid pulses; this keeps
    // a held request from re-issuing in the IDLE cycle after completion.
    assign d_pend  = bus.d_req & ~d_valid_q;
    assign f_pend  = bus.if_req & ~if_valid_q & ~bus.if_flush;
    assign issue_d = (state_q == IDLE) & d_pend;
    assign issue_f = (state_q == IDLE) & f_pend & ~d_pend;

    assign busy = (state_q != IDLE);
    assign done = busy & (bus.mem_ack | wd_expire);
    assign rsp  = bus.mem_ack ? bus.mem_rdata : '0;
    // Flush in the ack cycle still squashes this response.
    assign drop = discard_q | bus.if_flush;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (~busy | bus.mem_ack),
        .enable (busy & ~bus.mem_ack),
        .expire (wd_expire)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_valid_q   <= 1'b0;
            discard_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            d_rdata_q   <= d_rdata_d;
            d_valid_q   <= d_valid_d;
            discard_q   <= discard_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            issue_d: state_d = DATA;
            issue_f: state_d = FETCH;
            done:    state_d = IDLE;
            default: ;
        endcase
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_valid_d   = 1'b0;
        discard_d   = discard_q;
        err_d       = err_q | wd_expire;

        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    issue_d: begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_size_d  = bus.d_size;
                    end
                    issue_f: begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = bus.if_addr;
                        mem_size_d = MEM_SIZE_WORD;
                        discard_d  = 1'b0;
                    end
                    default: ;
                endcase
            end
            FETCH: begin
                if (done) begin
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    if (!drop) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = rsp;
                    end
                end else if (bus.if_flush) begin
                    discard_d = 1'b1;
                end
            end
            DATA: begin
                if (done) begin
                    mem_req_d = 1'b0;
                    d_valid_d = 1'b1;
                    d_rdata_d = mem_we_q ? '0 : rsp;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_size    = mem_size_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_stall    = bus.if_req & ~if_valid_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.d_valid     = d_valid_q;
    assign bus.d_stall     = bus.d_req & ~d_valid_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Instance a: TIMEOUT=255 with a latency-controlled memory; b: TIMEOUT=4, no ack.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
    } cmd_t;

    typedef struct {
        logic        d;
        logic [31:0] data;
    } rsp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mem_port_arbiter_if a();
    mem_port_arbiter_if b();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (a)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_wd (
        .CLK (CLK),
        .RST (RST),
        .bus (b)
    );

    int   errors = 0;
    int   checks = 0;
    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    logic [31:0] img [logic [31:0]];
    int          lat = 0;
    int          cnt = 0;
    logic        req_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within bound", name);
    endtask

    // Memory for instance a: acks 'lat' cycles after mem_req first seen.
    always @(negedge CLK) begin
        a.mem_ack = 1'b0;
        if (a.mem_req) begin
            if (cnt >= lat) begin
                a.mem_ack   = 1'b1;
                a.mem_rdata = img.exists(a.mem_addr) ? img[a.mem_addr]
                                                     : ~a.mem_addr;
                cnt = 0;
            end else begin
                cnt++;
            end
        end else begin
            cnt = 0;
        end
    end

    // Memory for instance b never acknowledges.
    always @(negedge CLK) begin
        b.mem_ack   = 1'b0;
        b.mem_rdata = 32'hBAD0_BAD0;
    end

    // Monitor: compare each issued command and each valid pulse.
    always @(posedge CLK) begin
        #1;
        if (!RST) begin
            if (a.mem_req && !req_prev) begin
                cmd_t e;
                if (cmd_q.size() == 0) begin
                    timeout_fail("unexpected_mem_req");
                end else begin
                    e = cmd_q.pop_front();
                    check("mem_addr", a.mem_addr, e.addr);
                    check("mem_we", 32'(a.mem_we), 32'(e.we));
                    check("mem_size", 32'(a.mem_size), 32'(e.size));
                    if (e.we) check("mem_wdata", a.mem_wdata, e.wdata);
                end
            end
            if (a.if_valid || a.d_valid) begin
                rsp_t r;
                if (rsp_q.size() == 0) begin
                    timeout_fail("unexpected_valid");
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_port_is_d", 32'(a.d_valid), 32'(r.d));
                    if (r.d) begin
                        check("d_rdata", a.d_rdata, r.data);
                        check("d_stall_on_valid", 32'(a.d_stall), 0);
                    end else begin
                        check("if_rdata", a.if_rdata, r.data);
                        check("if_stall_on_valid", 32'(a.if_stall), 0);
                    end
                end
            end
        end
        req_prev = a.mem_req;
    end

    task automatic wait_valid(input bit d, input string name, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(d ? a.d_valid : a.if_valid) && n < 64);
        if (!(d ? a.d_valid : a.if_valid)) timeout_fail(name);
    endtask

    task automatic wait_mem_req(input string name);
        int i = 0;
        while (!a.mem_req && i < 64) begin
            @(negedge CLK);
            i++;
        end
        if (!a.mem_req) timeout_fail(name);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int req_cycles;
        a.if_req = 0; a.if_addr = 0; a.if_flush = 0;
        a.d_req = 0; a.d_we = 0; a.d_addr = 0; a.d_wdata = 0; a.d_size = 0;
        b.if_req = 0; b.if_addr = 0; b.if_flush = 0;
        b.d_req = 0; b.d_we = 0; b.d_addr = 0; b.d_wdata = 0; b.d_size = 0;
        img[32'h0000_0100] = 32'h0050_0093;
        img[32'h0000_2000] = 32'hDEAD_BEEF;
        img[32'h0000_0200] = 32'h0000_0013;
        img[32'h0000_2004] = 32'h0000_00A5;

        repeat (2) @(negedge CLK);
        check("rst_mem_req", 32'(a.mem_req), 0);
        check("rst_mem_we", 32'(a.mem_we), 0);
        check("rst_mem_addr", a.mem_addr, 0);
        check("rst_mem_size", 32'(a.mem_size), 0);
        check("rst_if_valid", 32'(a.if_valid), 0);
        check("rst_d_valid", 32'(a.d_valid), 0);
        check("rst_d_rdata", a.d_rdata, 0);
        check("rst_err", 32'(a.err_timeout), 0);
        RST = 0;
        @(negedge CLK);

        // Fetch only, ack two cycles after mem_req.
        lat = 2;
        cmd_q.push_back('{1'b0, 32'h100, 32'h0, MEM_W});
        rsp_q.push_back('{1'b0, 32'h0050_0093});
        a.if_addr = 32'h100; a.if_req = 1;
        @(negedge CLK);
        check("if_stall_pending", 32'(a.if_stall), 1);
        wait_valid(0, "fetch_100", n);
        a.if_req = 0;
        check("fetch_100_latency", n + 1, 4);

        // Minimum latency: immediate ack.
        @(negedge CLK);
        lat = 0;
        cmd_q.push_back('{1'b0, 32'h300, 32'h0, MEM_W});
        rsp_q.push_back('{1'b0, 32'hFFFF_FCFF});
        a.if_addr = 32'h300; a.if_req = 1;
        wait_valid(0, "fetch_300", n);
        a.if_req = 0;
        check("min_latency", n, 2);

        // Flush in IDLE blocks issue for that cycle only.
        @(negedge CLK);
        cmd_q.push_back('{1'b0, 32'h304, 32'h0, MEM_W});
        rsp_q.push_back('{1'b0, 32'hFFFF_FCFB});
        a.if_addr = 32'h304; a.if_req = 1; a.if_flush = 1;
        @(negedge CLK);
        a.if_flush = 0;
        wait_valid(0, "fetch_304", n);
        a.if_req = 0;
        check("idle_flush_latency", n, 2);

        // Simultaneous requests: data wins, fetch after one IDLE cycle.
        @(negedge CLK);
        lat = 1;
        cmd_q.push_back('{1'b0, 32'h2000, 32'h0, MEM_W});
        cmd_q.push_back('{1'b0, 32'h108, 32'h0, MEM_W});
        rsp_q.push_back('{1'b1, 32'hDEAD_BEEF});
        rsp_q.push_back('{1'b0, 32'hFFFF_FEF7});
        a.if_addr = 32'h108; a.if_req = 1;
        a.d_addr = 32'h2000; a.d_we = 0; a.d_size = MEM_W; a.d_req = 1;
        wait_valid(1, "load_2000", n);
        a.d_req = 0;
        wait_valid(0, "fetch_108", n);
        a.if_req = 0;
        check("fetch_after_data_latency", n, 3);

        // Flush while fetch 0x104 is in flight; next fetch 0x200.
        @(negedge CLK);
        lat = 3;
        cmd_q.push_back('{1'b0, 32'h104, 32'h0, MEM_W});
        cmd_q.push_back('{1'b0, 32'h200, 32'h0, MEM_W});
        rsp_q.push_back('{1'b0, 32'h0000_0013});
        a.if_addr = 32'h104; a.if_req = 1;
        wait_mem_req("fetch_104_issue");
        a.if_flush = 1; a.if_addr = 32'h200;
        @(negedge CLK);
        a.if_flush = 0;
        wait_valid(0, "fetch_200", n);
        a.if_req = 0;

        // Store: read data forced to zero.
        @(negedge CLK);
        lat = 1;
        cmd_q.push_back('{1'b1, 32'h3000, 32'h1234_5678, MEM_W});
        rsp_q.push_back('{1'b1, 32'h0});
        a.d_addr = 32'h3000; a.d_we = 1; a.d_wdata = 32'h1234_5678;
        a.d_size = MEM_W; a.d_req = 1;
        @(negedge CLK);
        check("d_stall_pending", 32'(a.d_stall), 1);
        wait_valid(1, "store_3000", n);
        a.d_req = 0; a.d_we = 0;

        // Load with d_req dropped early still completes.
        @(negedge CLK);
        lat = 2;
        cmd_q.push_back('{1'b0, 32'h2004, 32'h0, MEM_BU});
        rsp_q.push_back('{1'b1, 32'h0000_00A5});
        a.d_addr = 32'h2004; a.d_size = MEM_BU; a.d_req = 1;
        wait_mem_req("load_2004_issue");
        a.d_req = 0;
        wait_valid(1, "load_2004", n);

        // Watchdog on instance b: no ack ever.
        @(negedge CLK);
        b.d_addr = 32'h5000; b.d_size = MEM_W; b.d_req = 1;
        req_cycles = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            if (b.d_valid) break;
            if (b.mem_req) req_cycles++;
        end
        check("wd_d_valid", 32'(b.d_valid), 1);
        check("wd_req_cycles", req_cycles, 4);
        check("wd_d_rdata", b.d_rdata, 0);
        check("wd_err", 32'(b.err_timeout), 1);
        b.d_req = 0;
        repeat (3) @(negedge CLK);
        check("wd_err_sticky", 32'(b.err_timeout), 1);
        check("wd_mem_req_low", 32'(b.mem_req), 0);
        check("a_err_clear", 32'(a.err_timeout), 0);

        // Reset mid-DATA: mem_req drops without a clock edge.
        lat = 20;
        cmd_q.push_back('{1'b0, 32'h4000, 32'h0, MEM_W});
        a.d_addr = 32'h4000; a.d_size = MEM_W; a.d_req = 1;
        wait_mem_req("load_4000_issue");
        @(negedge CLK);
        #2 RST = 1;
        #1;
        check("rst_async_mem_req", 32'(a.mem_req), 0);
        check("rst_err_b", 32'(b.err_timeout), 0);
        a.d_req = 0;
        @(negedge CLK);
        RST = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("post_rst_idle", {30'd0, a.mem_req, a.d_valid}, 0);
        end
        lat = 0;
        cmd_q.push_back('{1'b0, 32'h300, 32'h0, MEM_W});
        rsp_q.push_back('{1'b0, 32'hFFFF_FCFF});
        a.if_addr = 32'h300; a.if_req = 1;
        wait_valid(0, "fetch_after_rst", n);
        a.if_req = 0;
        check("post_rst_latency", n, 2);

        repeat (4) @(negedge CLK);
        check("cmd_left", cmd_q.size(), 0);
        check("rsp_left", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, variable-latency memory between the instruction-fetch stage (requester IF) and the memory stage (requester D) of the 5-stage pipeline.
Data accesses have fixed priority because they belong to the older instruction.
The block generates per-stage stall signals for the hazard/stall logic, and discards fetch responses for flushed fetches.
A watchdog flags a memory that never acknowledges.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles waiting for mem_ack before error; 0 disables watchdog

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
if_req  in  1  fetch request; held until if_valid or if_flush
if_addr  in  ADDR_W  fetch address (pc)
if_flush  in  1  fetch in IF stage is squashed (branch/jump taken)
if_rdata  out  DATA_W  fetched instruction, valid with if_valid
if_valid  out  1  one-cycle pulse, fetch complete
if_stall  out  1  if_req & ~if_valid
d_req  in  1  load/store request; held until d_valid
d_we  in  1  1 = store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_size  in  3  mem_type encoding (sign, size)
d_rdata  out  DATA_W  load data, valid with d_valid
d_valid  out  1  one-cycle pulse, data access complete
d_stall  out  1  d_req & ~d_valid
mem_req  out  1  request to memory; held until mem_ack
mem_we  out  1  write enable
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_size  out  3  access size/sign
mem_ack  in  1  memory done; mem_rdata valid this cycle
mem_rdata  in  DATA_W  read data
err_timeout  out  1  sticky watchdog error

Behaviour:
- Clocking and reset: one clock CLK; RST is asynchronous and active-high.
- Reset values: state IDLE; mem_req, mem_we, if_valid, d_valid, err_timeout, discard flag, watchdog counter = 0; mem_addr, mem_wdata, mem_size, if_rdata, d_rdata = 0. RST mid-transaction drops mem_req immediately; the memory must abandon the transfer.
- States:
  - IDLE
  - FETCH (IF transaction outstanding)
  - DATA (D transaction outstanding)
- IDLE:
  - d_req=1 → latch d_we/d_addr/d_wdata/d_size onto the mem_* registers, mem_req<=1, go DATA. This takes priority over if_req in the same cycle.
  - Else if_req=1 & ~if_flush → latch if_addr, mem_we<=0, mem_size<=word, mem_req<=1, go FETCH.
  - Else stay IDLE.
- mem_* outputs are registered and stay stable while mem_req=1.
- DATA, on mem_ack: mem_req<=0; d_rdata<=mem_rdata (0 for stores); d_valid<=1 for one cycle; go IDLE.
- FETCH, on mem_ack: mem_req<=0; go IDLE.
  - If the discard flag is clear: if_rdata<=mem_rdata, if_valid<=1 for one cycle.
  - If the discard flag is set: no if_valid; clear the flag.
- if_flush while in FETCH (including the ack cycle) sets the discard flag. The transaction always completes on the bus; transactions are never aborted.
- if_flush in IDLE blocks issue that cycle only.
- Minimum latency: request seen in IDLE at cycle N → mem_req at N+1 → ack no earlier than N+1 → valid at N+2.
- At least one IDLE cycle between transactions, so a waiting requester is reconsidered after every ack.
- Dropping d_req before d_valid does not cancel; d_valid still pulses.
- if_stall and d_stall are combinational from request inputs and registered valids.
- Watchdog:
  - Counter increments each cycle in FETCH/DATA without ack; clears on ack or in IDLE.
  - When the count reaches TIMEOUT (TIMEOUT≠0): err_timeout<=1 (sticky until RST), mem_req<=0, the matching valid pulses with rdata=0, go IDLE.
  - Counter is 8 bits, saturating; no wrap.
- Starvation: fetch waits while d_req is held. Acceptable because the pipeline stalls IF while a memory-stage access is pending.

Decomposition:
- Shared package: arb_state_t enum {IDLE, FETCH, DATA}; the mem_type size/sign constants already used by the decoder and instr_t; MEM_SIZE_WORD constant.
- One sub-module: arb_watchdog (TIMEOUT parameter, clear/enable inputs, expire output).

Test Plan:
1. Fetch only: if_req=1, if_addr=0x100, memory acks 2 cycles after mem_req → mem_addr=0x100, mem_we=0, if_valid one cycle with if_rdata=0x00500093, if_stall low that cycle.
2. Simultaneous: if_req and d_req (load 0x2000) in the same IDLE cycle → data first, d_valid with mem_rdata=0xDEADBEEF; IDLE one cycle; then fetch issues.
3. Flush in flight: fetch 0x104 issued, if_flush pulsed the next cycle, ack 3 cycles later → no if_valid; the next if_req 0x200 issues normally.
4. Store: d_we=1, d_addr=0x3000, d_wdata=0x12345678, d_size=word → mem_* match; d_valid one cycle, d_rdata=0.
5. Timeout: TIMEOUT=4, no mem_ack → mem_req drops after 4 wait cycles, err_timeout=1 sticky, d_valid pulses with rdata=0.
6. RST asserted mid-DATA → mem_req=0 asynchronously; no valid pulse; IDLE after release.
